cart_loader: RTL and testbench
==============================

# cart_loader

Cartridge download stage between the HPS ioctl stream and the `scv` cartridge ROM port. It accepts the byte stream for the cartridge index and writes it into cartridge memory over a request/acknowledge handshake, stalling the HPS with `IOCTL_WAIT` while a write is outstanding. At the end of the download it classifies the image size into a mapper/mirroring configuration for the console. It drives `CART_BUSY` so the top level can hold the console in reset while a load is in progress.

## Interface
Parameters:
- `CART_INDEX`, default 8'd1: `IOCTL_INDEX` value that selects a cartridge download.
- `ADDR_W`, default 17: cartridge address width; 128 KiB maximum image.

Ports:
- `CLK`  in  1  system clock.
- `RESB`  in  1  reset; asynchronous, active-low.
- `IOCTL_DOWNLOAD`  in  1  HPS download active.
- `IOCTL_INDEX`  in  8  download target selector.
- `IOCTL_WR`  in  1  one-cycle byte strobe.
- `IOCTL_ADDR`  in  25  byte address within the image.
- `IOCTL_DOUT`  in  8  byte data.
- `IOCTL_WAIT`  out  1  stall request to the HPS.
- `CART_ADDR`  out  ADDR_W  memory write address.
- `CART_DATA`  out  8  memory write data.
- `CART_WE`  out  1  write request; held until acknowledged.
- `CART_ACK`  in  1  memory accepted the write; one-cycle pulse.
- `CART_BUSY`  out  1  a cartridge load is in progress.
- `CART_VALID`  out  1  a non-empty image is loaded and classified.
- `CART_MAPPER`  out  `cart_mapper_t`  size class of the loaded image.
- `CART_MASK`  out  ADDR_W  address mirror mask; class size minus one.
- `CART_OVF`  out  1  at least one byte with `IOCTL_ADDR >= 2**ADDR_W` was dropped.

## Operation
- FSM states: `ST_IDLE`, `ST_RECV`, `ST_WRITE`, `ST_FINISH`.
- `ST_IDLE`
  - `CART_VALID`, `CART_MAPPER` and `CART_MASK` keep the result of the previous load.
  - On `IOCTL_DOWNLOAD=1` with `IOCTL_INDEX==CART_INDEX`: clear `CART_VALID`, `CART_OVF` and the byte counter `size`; set `CART_BUSY`; go to `ST_RECV`.
  - Downloads for any other index are ignored entirely.
- `ST_RECV`
  - On `IOCTL_WR` with an in-range address: latch address and data, assert `CART_WE` and `IOCTL_WAIT`, update `size = max(size, IOCTL_ADDR+1)`, go to `ST_WRITE`.
  - On `IOCTL_WR` with an out-of-range address: set `CART_OVF`, drop the byte, do not stall, leave `size` unchanged.
  - On `IOCTL_DOWNLOAD=0` with no `IOCTL_WR` in the same cycle: go to `ST_FINISH`.
  - If `IOCTL_WR` and the fall of `IOCTL_DOWNLOAD` coincide: the write is taken first; `ST_WRITE` then exits to `ST_FINISH`.
- `ST_WRITE`
  - Hold `CART_ADDR`, `CART_DATA` and `CART_WE` stable until `CART_ACK`.
  - On `CART_ACK`: deassert `CART_WE` and `IOCTL_WAIT` on the next edge. Go to `ST_FINISH` if `IOCTL_DOWNLOAD` has fallen (level sampled that cycle), otherwise back to `ST_RECV`.
- `ST_FINISH` (one cycle)
  - Classify `size` (width ADDR_W+1):
    - 0 → `CM_NONE`, `CART_VALID` stays 0
    - ≤8192 → `CM_8K`
    - ≤16384 → `CM_16K`
    - ≤32768 → `CM_32K`
    - ≤65536 → `CM_64K`
    - otherwise → `CM_128K`
  - `CART_MASK` = class size − 1; all zeros for `CM_NONE`.
  - Set `CART_VALID` for non-empty images, clear `CART_BUSY`, go to `ST_IDLE`.
- `CART_ACK` outside `ST_WRITE` is ignored.
- Reset mid-load: all state returns to reset values immediately. A partially written memory is not cleared; `CART_VALID=0` marks it unusable.

## Timing
- Reset values:
  - `IOCTL_WAIT`, `CART_WE`, `CART_BUSY`, `CART_VALID`, `CART_OVF` = 0
  - `CART_ADDR`, `CART_DATA`, `CART_MASK` = 0
  - `CART_MAPPER` = `CM_NONE`
  - FSM in `ST_IDLE`
- All outputs are registered.
- `CART_WE` and `IOCTL_WAIT` rise on the edge after the cycle carrying `IOCTL_WR`, and fall on the edge after the `CART_ACK` cycle.
- Minimum write occupancy is 2 cycles (zero-latency ack). Back-to-back `IOCTL_WR` is therefore never accepted while `IOCTL_WAIT=1`; a strobe arriving then is a protocol violation and is ignored.
- `CART_BUSY` rises 1 cycle after the matching download is seen. `CART_VALID` and the mapper outputs update 1 cycle after entering `ST_FINISH`.
- Download start and end detection uses `IOCTL_DOWNLOAD` levels; no edge detector is needed.

## Structure
- `scv_pkg` gets:
  - `typedef enum logic [2:0] cart_mapper_t {CM_NONE, CM_8K, CM_16K, CM_32K, CM_64K, CM_128K}`
  - the default cartridge index constant
- Single module, no sub-modules. The size classifier is a combinational function local to the module.

## Test plan
- 8192-byte load, `CART_ACK` 1 cycle after `CART_WE`:
  - every byte appears at its `CART_ADDR` exactly once
  - `IOCTL_WAIT` high for 2 cycles per byte
  - final state `CM_8K`, `CART_MASK=0x01FFF`, `CART_VALID=1`
- 20000-byte load with ack delayed 5 cycles:
  - `CART_WE`, address and data stable throughout each wait
  - final state `CM_32K`, `CART_MASK=0x07FFF`
- Download with index 0 (boot ROM): no `CART_WE`, `CART_BUSY` stays 0, previous `CART_VALID`/`CART_MAPPER` retained.
- 0x20010-byte image:
  - bytes at address ≥0x20000 dropped without stall, `CART_OVF=1`
  - final state `CM_128K`, `CART_MASK=0x1FFFF`
- Final `IOCTL_WR` coincident with the `IOCTL_DOWNLOAD` fall: the byte is written, then `CART_VALID=1`. Empty download (no `IOCTL_WR`) ends with `CM_NONE`, `CART_VALID=0`.
- `RESB` pulsed low while in `ST_WRITE`: outputs at reset values on the same edge; a following 4096-byte load gives `CM_8K`.

Source files
------------

// File: rtl/scv_pkg.sv
// Shared types and constants for the SCV console cartridge path.
package scv_pkg;

   typedef enum logic [2:0] {
      CM_NONE,
      CM_8K,
      CM_16K,
      CM_32K,
      CM_64K,
      CM_128K
   } cart_mapper_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_FINISH
   } cart_state_t;

   localparam logic [7:0] CART_INDEX_DEFAULT = 8'd1;

endpackage

// File: rtl/cart_loader.sv
// Writes the HPS ioctl cartridge stream into cartridge memory over a WE/ACK
// handshake and classifies the final image size into a mapper configuration.
module cart_loader
   import scv_pkg::*;
#(
   parameter logic [7:0] CART_INDEX = CART_INDEX_DEFAULT,
   parameter int         ADDR_W     = 17
) (
   input  logic              CLK,
   input  logic              RESB,
   input  logic              IOCTL_DOWNLOAD,
   input  logic [7:0]        IOCTL_INDEX,
   input  logic              IOCTL_WR,
   input  logic [24:0]       IOCTL_ADDR,
   input  logic [7:0]        IOCTL_DOUT,
   output logic              IOCTL_WAIT,
   output logic [ADDR_W-1:0] CART_ADDR,
   output logic [7:0]        CART_DATA,
   output logic              CART_WE,
   input  logic              CART_ACK,
   output logic              CART_BUSY,
   output logic              CART_VALID,
   output cart_mapper_t      CART_MAPPER,
   output logic [ADDR_W-1:0] CART_MASK,
   output logic              CART_OVF
);

   cart_state_t     state;
   logic [ADDR_W:0] size;
   logic [ADDR_W:0] next_end;
   logic            in_range;
   cart_mapper_t    fin_mapper;

   function automatic cart_mapper_t classify(input logic [ADDR_W:0] sz);
      logic [31:0] s;
      s = 32'(sz);
      if (s == 32'd0)           return CM_NONE;
      else if (s <= 32'd8192)   return CM_8K;
      else if (s <= 32'd16384)  return CM_16K;
      else if (s <= 32'd32768)  return CM_32K;
      else if (s <= 32'd65536)  return CM_64K;
      else                      return CM_128K;
   endfunction

   function automatic logic [ADDR_W-1:0] class_mask(input cart_mapper_t m);
      logic [31:0] full;
      // NOTE: default before the case keeps every path assigned, so no latch.
      full = '0;
      case (m)
         CM_8K:   full = 32'h0000_1FFF;
         CM_16K:  full = 32'h0000_3FFF;
         CM_32K:  full = 32'h0000_7FFF;
         CM_64K:  full = 32'h0000_FFFF;
         CM_128K: full = 32'h0001_FFFF;
         default: full = '0;
      endcase
      return full[ADDR_W-1:0];
   endfunction

   assign in_range   = (IOCTL_ADDR >> ADDR_W) == 25'd0;
   assign next_end   = {1'b0, IOCTL_ADDR[ADDR_W-1:0]} + (ADDR_W+1)'(1);
   assign fin_mapper = classify(size);

   // NOTE: asynchronous reset acts immediately; all state uses non-blocking
   // assignments so every register sees pre-edge values.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state       <= ST_IDLE;
         size        <= '0;
         IOCTL_WAIT  <= 1'b0;
         CART_ADDR   <= '0;
         CART_DATA   <= '0;
         CART_WE     <= 1'b0;
         CART_BUSY   <= 1'b0;
         CART_VALID  <= 1'b0;
         CART_MAPPER <= CM_NONE;
         CART_MASK   <= '0;
         CART_OVF    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (IOCTL_DOWNLOAD && (IOCTL_INDEX == CART_INDEX)) begin
                  CART_VALID <= 1'b0;
                  CART_OVF   <= 1'b0;
                  size       <= '0;
                  CART_BUSY  <= 1'b1;
                  state      <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (IOCTL_WR) begin
                  if (in_range) begin
                     CART_ADDR  <= IOCTL_ADDR[ADDR_W-1:0];
                     CART_DATA  <= IOCTL_DOUT;
                     CART_WE    <= 1'b1;
                     IOCTL_WAIT <= 1'b1;
                     if (next_end > size) size <= next_end;
                     state      <= ST_WRITE;
                  end else begin
                     // Bytes past the window are dropped without stalling.
                     CART_OVF <= 1'b1;
                  end
               end else if (!IOCTL_DOWNLOAD) begin
                  state <= ST_FINISH;
               end
            end
            ST_WRITE: begin
               if (CART_ACK) begin
                  CART_WE    <= 1'b0;
                  IOCTL_WAIT <= 1'b0;
                  state      <= IOCTL_DOWNLOAD ? ST_RECV : ST_FINISH;
               end
            end
            ST_FINISH: begin
               CART_MAPPER <= fin_mapper;
               CART_MASK   <= class_mask(fin_mapper);
               CART_VALID  <= (fin_mapper != CM_NONE);
               CART_BUSY   <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: a memory responder with programmable ack
// latency, host-side byte driver, and hand-computed classification results.
module tb_cart_loader;
   import scv_pkg::*;

   logic         CLK;
   logic         RESB;
   logic         IOCTL_DOWNLOAD;
   logic [7:0]   IOCTL_INDEX;
   logic         IOCTL_WR;
   logic [24:0]  IOCTL_ADDR;
   logic [7:0]   IOCTL_DOUT;
   logic         IOCTL_WAIT;
   logic [16:0]  CART_ADDR;
   logic [7:0]   CART_DATA;
   logic         CART_WE;
   logic         CART_ACK;
   logic         CART_BUSY;
   logic         CART_VALID;
   cart_mapper_t CART_MAPPER;
   logic [16:0]  CART_MASK;
   logic         CART_OVF;

   cart_loader dut (
      .CLK(CLK), .RESB(RESB),
      .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
      .IOCTL_WR(IOCTL_WR), .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT),
      .IOCTL_WAIT(IOCTL_WAIT),
      .CART_ADDR(CART_ADDR), .CART_DATA(CART_DATA), .CART_WE(CART_WE),
      .CART_ACK(CART_ACK), .CART_BUSY(CART_BUSY), .CART_VALID(CART_VALID),
      .CART_MAPPER(CART_MAPPER), .CART_MASK(CART_MASK), .CART_OVF(CART_OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem    [0:131071];
   int         wr_cnt [0:131071];
   int  wr_total, stab_bad, wait_cycles, stall_bad, tmo;
   int  ack_delay, wait_cnt;
   bit  ack_hold, we_seen, busy_seen;
   logic [16:0] hold_addr;
   logic [7:0]  hold_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Memory side: acks each write ack_delay cycles after WE is first seen.
   initial begin
      CART_ACK = 1'b0;
      wait_cnt = 0;
      forever begin
         @(negedge CLK);
         CART_ACK = 1'b0;
         if (CART_WE) begin
            if (wait_cnt == 0) begin
               hold_addr = CART_ADDR;
               hold_data = CART_DATA;
            end else if (CART_ADDR !== hold_addr || CART_DATA !== hold_data) begin
               stab_bad++;
            end
            if (!ack_hold && wait_cnt >= ack_delay) begin
               CART_ACK = 1'b1;
               mem[CART_ADDR] = CART_DATA;
               wr_cnt[CART_ADDR]++;
               wr_total++;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (IOCTL_WAIT) wait_cycles++;
         if (CART_WE)    we_seen = 1'b1;
         if (CART_BUSY)  busy_seen = 1'b1;
      end
   end

   task automatic clear_phase();
      for (int i = 0; i < 131072; i++) begin
         wr_cnt[i] = 0;
         mem[i]    = 8'h00;
      end
      wr_total = 0; stab_bad = 0; wait_cycles = 0; stall_bad = 0;
      we_seen = 1'b0; busy_seen = 1'b0;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      IOCTL_INDEX    = idx;
      IOCTL_DOWNLOAD = 1'b1;
      @(negedge CLK);
   endtask

   task automatic end_dl();
      IOCTL_DOWNLOAD = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic send_byte(input logic [24:0] a, input bit last);
      int n;
      IOCTL_ADDR = a;
      IOCTL_DOUT = pat(a);
      IOCTL_WR   = 1'b1;
      if (last) IOCTL_DOWNLOAD = 1'b0;
      @(negedge CLK);
      IOCTL_WR = 1'b0;
      if (a >= 25'h20000) begin
         if (IOCTL_WAIT) stall_bad++;
      end else begin
         n = 0;
         while (IOCTL_WAIT && n < 200) begin
            @(negedge CLK);
            n++;
         end
         if (n >= 200) tmo++;
      end
   endtask

   task automatic single_load(input string tag, input logic [24:0] a,
                              input cart_mapper_t m, input logic [16:0] mk);
      start_dl(8'd1);
      send_byte(a, 1'b0);
      end_dl();
      check({tag, "_mapper"}, 32'(CART_MAPPER), 32'(m));
      check({tag, "_mask"}, 32'(CART_MASK), 32'(mk));
   endtask

   int bad;

   initial begin
      RESB = 1'b0; IOCTL_DOWNLOAD = 1'b0; IOCTL_INDEX = 8'd0; IOCTL_WR = 1'b0;
      IOCTL_ADDR = '0; IOCTL_DOUT = '0;
      ack_delay = 1; ack_hold = 1'b0; tmo = 0;
      clear_phase();
      @(negedge CLK);
      check("rst_we", 32'(CART_WE), 32'd0);
      check("rst_wait", 32'(IOCTL_WAIT), 32'd0);
      check("rst_busy", 32'(CART_BUSY), 32'd0);
      check("rst_valid", 32'(CART_VALID), 32'd0);
      check("rst_mapper", 32'(CART_MAPPER), 32'(CM_NONE));
      @(negedge CLK);
      RESB = 1'b1;
      @(negedge CLK);

      // Full 8 KiB image, ack one cycle after WE.
      clear_phase();
      ack_delay = 1;
      start_dl(8'd1);
      check("p1_busy_rise", 32'(CART_BUSY), 32'd1);
      for (int i = 0; i < 8192; i++) send_byte(25'(i), 1'b0);
      end_dl();
      bad = 0;
      for (int i = 0; i < 8192; i++)
         if (wr_cnt[i] != 1 || mem[i] !== pat(25'(i))) bad++;
      check("p1_bytes", 32'(bad), 32'd0);
      check("p1_writes", 32'(wr_total), 32'd8192);
      check("p1_wait_cycles", 32'(wait_cycles), 32'd16384);
      check("p1_mapper", 32'(CART_MAPPER), 32'(CM_8K));
      check("p1_mask", 32'(CART_MASK), 32'h01FFF);
      check("p1_valid", 32'(CART_VALID), 32'd1);
      check("p1_busy_fall", 32'(CART_BUSY), 32'd0);

      // 20000-byte image (sparse), ack delayed 5 cycles.
      clear_phase();
      ack_delay = 5;
      start_dl(8'd1);
      for (int i = 0; i < 32; i++) send_byte(25'(i), 1'b0);
      send_byte(25'd10000, 1'b0);
      send_byte(25'd19999, 1'b0);
      end_dl();
      check("p2_stable", 32'(stab_bad), 32'd0);
      check("p2_writes", 32'(wr_total), 32'd34);
      check("p2_last_byte", 32'(mem[19999]), 32'(pat(25'd19999)));
      check("p2_mapper", 32'(CART_MAPPER), 32'(CM_32K));
      check("p2_mask", 32'(CART_MASK), 32'h07FFF);

      // Boot ROM download (index 0) must be ignored.
      clear_phase();
      ack_delay = 0;
      start_dl(8'd0);
      for (int i = 0; i < 4; i++) send_byte(25'(i + 40), 1'b0);
      end_dl();
      check("p3_no_we", 32'(we_seen), 32'd0);
      check("p3_no_busy", 32'(busy_seen), 32'd0);
      check("p3_valid_kept", 32'(CART_VALID), 32'd1);
      check("p3_mapper_kept", 32'(CART_MAPPER), 32'(CM_32K));

      // 0x20010-byte image: top 16 bytes fall outside the window.
      clear_phase();
      start_dl(8'd1);
      for (int i = 0; i < 32; i++) send_byte(25'(32'h1FFF0 + i), 1'b0);
      end_dl();
      bad = 0;
      for (int i = 0; i < 16; i++) bad += wr_cnt[i];
      check("p4_ovf", 32'(CART_OVF), 32'd1);
      check("p4_no_stall", 32'(stall_bad), 32'd0);
      check("p4_writes", 32'(wr_total), 32'd16);
      check("p4_no_alias", 32'(bad), 32'd0);
      check("p4_top_byte", 32'(wr_cnt[131071]), 32'd1);
      check("p4_mapper", 32'(CART_MAPPER), 32'(CM_128K));
      check("p4_mask", 32'(CART_MASK), 32'h1FFFF);

      // Class boundaries with single-byte images.
      start_dl(8'd1);
      check("p5_ovf_cleared", 32'(CART_OVF), 32'd0);
      send_byte(25'd8191, 1'b0);
      end_dl();
      check("b8191_mapper", 32'(CART_MAPPER), 32'(CM_8K));
      single_load("b8192", 25'd8192, CM_16K, 17'h03FFF);
      single_load("b16383", 25'd16383, CM_16K, 17'h03FFF);
      single_load("b16384", 25'd16384, CM_32K, 17'h07FFF);
      single_load("b65535", 25'd65535, CM_64K, 17'h0FFFF);
      single_load("b65536", 25'd65536, CM_128K, 17'h1FFFF);

      // Size tracks the maximum address, not the last one.
      start_dl(8'd1);
      send_byte(25'd40000, 1'b0);
      send_byte(25'd5, 1'b0);
      end_dl();
      check("max_mapper", 32'(CART_MAPPER), 32'(CM_64K));

      // Last strobe coincides with the download fall.
      clear_phase();
      start_dl(8'd1);
      send_byte(25'd0, 1'b0);
      send_byte(25'd100, 1'b1);
      @(negedge CLK);
      check("coin_written", 32'(wr_cnt[100]), 32'd1);
      check("coin_valid", 32'(CART_VALID), 32'd1);
      check("coin_mapper", 32'(CART_MAPPER), 32'(CM_8K));

      // Reset while a write is outstanding.
      ack_hold = 1'b1;
      start_dl(8'd1);
      IOCTL_ADDR = 25'd5; IOCTL_DOUT = 8'hA5; IOCTL_WR = 1'b1;
      @(negedge CLK);
      IOCTL_WR = 1'b0;
      @(negedge CLK);
      check("rw_we_pending", 32'(CART_WE), 32'd1);
      RESB = 1'b0;
      #1;
      check("rw_we", 32'(CART_WE), 32'd0);
      check("rw_wait", 32'(IOCTL_WAIT), 32'd0);
      check("rw_busy", 32'(CART_BUSY), 32'd0);
      check("rw_valid", 32'(CART_VALID), 32'd0);
      check("rw_addr", 32'(CART_ADDR), 32'd0);
      check("rw_data", 32'(CART_DATA), 32'd0);
      check("rw_mask", 32'(CART_MASK), 32'd0);
      check("rw_mapper", 32'(CART_MAPPER), 32'(CM_NONE));
      IOCTL_DOWNLOAD = 1'b0;
      ack_hold = 1'b0;
      @(negedge CLK);
      RESB = 1'b1;
      @(negedge CLK);

      clear_phase();
      ack_delay = 0;
      start_dl(8'd1);
      for (int i = 0; i < 4096; i++) send_byte(25'(i), 1'b0);
      end_dl();
      check("r4k_writes", 32'(wr_total), 32'd4096);
      check("r4k_mapper", 32'(CART_MAPPER), 32'(CM_8K));
      check("r4k_mask", 32'(CART_MASK), 32'h01FFF);
      check("r4k_valid", 32'(CART_VALID), 32'd1);

      // Empty download.
      start_dl(8'd1);
      end_dl();
      check("empty_mapper", 32'(CART_MAPPER), 32'(CM_NONE));
      check("empty_valid", 32'(CART_VALID), 32'd0);
      check("empty_mask", 32'(CART_MASK), 32'd0);
      check("empty_busy", 32'(CART_BUSY), 32'd0);

      check("wait_timeouts", 32'(tmo), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
